// File: rtl/sc_mult_sequencer.sv
// ============================================================================
// Module      : sc_mult_sequencer
// Description : Stochastic-computing sequencer: one AND-multiply or MUX
//               scaled-add operation per start, ones-counted over STREAM_LEN.
//               Optional macro SC_ABORT_EN adds an abort_i input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_mult_sequencer #(
    parameter int         STREAM_LEN = 255,
    parameter logic [7:0] SEED_A     = 8'h01,
    parameter logic [7:0] SEED_B     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SC_ABORT_EN
    input  logic       abort_i,
`endif
    input  logic       start_i,
    input  logic [7:0] op_a_i,
    input  logic [7:0] op_b_i,
    input  logic       mode_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] result_o,
    output logic       sn_out_o
);

    localparam logic [8:0] POLY_A   = 9'h11D;
    localparam logic [8:0] POLY_B   = 9'h12D;
    localparam logic [7:0] LAST_CYC = 8'(STREAM_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q;
    logic [7:0] a_q, b_q;
    logic       mode_q;
    logic [7:0] lfsr_a_q, lfsr_b_q;
    logic [7:0] lfsr_a_d, lfsr_b_d;
    logic [7:0] ones_q, cyc_q;
    logic       sel_q;
    logic       done_q;
    logic [7:0] result_q;

    logic       sn_a, sn_b, sn_mix;
    logic       abort_w;

`ifdef SC_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Galois left-shift step; the x^8 term is implied by the shifted-out MSB.
    always_comb begin
        lfsr_a_d = {lfsr_a_q[6:0], 1'b0} ^ (lfsr_a_q[7] ? POLY_A[7:0] : 8'h00);
        lfsr_b_d = {lfsr_b_q[6:0], 1'b0} ^ (lfsr_b_q[7] ? POLY_B[7:0] : 8'h00);
    end

    assign sn_a   = (lfsr_a_q != 8'h00) && (lfsr_a_q <= a_q);
    assign sn_b   = (lfsr_b_q != 8'h00) && (lfsr_b_q <= b_q);
    assign sn_mix = mode_q ? (sel_q ? sn_b : sn_a) : (sn_a & sn_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            mode_q   <= 1'b0;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            ones_q   <= 8'h00;
            cyc_q    <= 8'h00;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q      <= op_a_i;
                        b_q      <= op_b_i;
                        mode_q   <= mode_i;
                        lfsr_a_q <= SEED_A;
                        lfsr_b_q <= SEED_B;
                        ones_q   <= 8'h00;
                        cyc_q    <= 8'h00;
                        sel_q    <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    ones_q   <= ones_q + {7'b0, sn_mix};
                    lfsr_a_q <= lfsr_a_d;
                    lfsr_b_q <= lfsr_b_d;
                    sel_q    <= ~sel_q;
                    cyc_q    <= cyc_q + 8'd1;
                    // Abort wins over a completion landing on the same edge.
                    if (abort_w) begin
                        state_q <= IDLE;
                    end else if (cyc_q == LAST_CYC) begin
                        result_q <= ones_q + {7'b0, sn_mix};
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q == RUN);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign sn_out_o = (state_q == RUN) ? sn_mix : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sc_mult_sequencer.sv
// ============================================================================
// Module      : tb_sc_mult_sequencer
// Description : Directed self-checking bench for sc_mult_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       mode = 1'b0;
    logic       busy_o, done_o, sn_out_o;
    logic [7:0] result_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sc_mult_sequencer #(
        .STREAM_LEN (255),
        .SEED_A     (8'h01),
        .SEED_B     (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SC_ABORT_EN
        .abort_i  (abort),
`endif
        .start_i  (start),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .mode_i   (mode),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .sn_out_o (sn_out_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full operation; optionally pulses a stray start (op_b=7) at cycle inject_at.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input int inject_at, input logic [7:0] exp_res, input string tag);
        int n, busy_cnt, ones_cnt;
        op_a = a; op_b = b; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; busy_cnt = 0; ones_cnt = 0;
        while (!done_o && n < 400) begin
            if (busy_o) busy_cnt++;
            if (busy_o && sn_out_o) ones_cnt++;
            if (n == inject_at) begin
                start = 1'b1; op_b = 8'd7; op_a = 8'd0;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, 255);
        check({tag, "_busy_cycles"}, busy_cnt, 255);
        check({tag, "_stream_ones"}, ones_cnt, {24'd0, exp_res});
        check({tag, "_result"}, {24'd0, result_o}, {24'd0, exp_res});
        tick();
        check({tag, "_done_single"}, {31'd0, done_o}, 0);
        check({tag, "_idle_after"}, {31'd0, busy_o}, 0);
    endtask

    initial begin
        #2;
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_result", {24'd0, result_o}, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("idle_busy", {31'd0, busy_o}, 0);
        check("idle_done", {31'd0, done_o}, 0);
        check("idle_result", {24'd0, result_o}, 0);
        check("idle_sn_out", {31'd0, sn_out_o}, 0);

        run_op(8'd255, 8'd100, 1'b0, -1, 8'd100, "mul_255x100");
        run_op(8'd0,   8'd200, 1'b0, -1, 8'd0,   "mul_0x200");
        run_op(8'd100, 8'd255, 1'b0, -1, 8'd100, "mul_100x255");
        run_op(8'd255, 8'd255, 1'b1, -1, 8'd255, "add_255_255");
        run_op(8'd0,   8'd0,   1'b1, -1, 8'd0,   "add_0_0");
        run_op(8'd255, 8'd0,   1'b1, -1, 8'd128, "add_255_0");
        run_op(8'd0,   8'd255, 1'b1, -1, 8'd127, "add_0_255");
        run_op(8'd255, 8'd100, 1'b0, 50, 8'd100, "start_busy");

        // Asynchronous reset in the middle of a run.
        op_a = 8'd255; op_b = 8'd100; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        check("mid_busy_before", {31'd0, busy_o}, 1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy_o}, 0);
        check("mid_rst_done", {31'd0, done_o}, 0);
        check("mid_rst_result", {24'd0, result_o}, 0);
        check("mid_rst_sn_out", {31'd0, sn_out_o}, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", {31'd0, busy_o}, 0);
        run_op(8'd255, 8'd100, 1'b0, -1, 8'd100, "post_rst");

`ifdef SC_ABORT_EN
        op_a = 8'd255; op_b = 8'd200; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy_o}, 0);
        check("abort_done", {31'd0, done_o}, 0);
        check("abort_result", {24'd0, result_o}, 100);

        op_a = 8'd255; op_b = 8'd200; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (254) tick();
        check("abort_last_busy_pre", {31'd0, busy_o}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last_done", {31'd0, done_o}, 0);
        check("abort_last_busy", {31'd0, busy_o}, 0);
        check("abort_last_result", {24'd0, result_o}, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_busy", {31'd0, busy_o}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
